// File: rtl/adder_result_fifo_if.sv
// Handshake bundle between an adder-result producer/consumer and the FIFO.
// The master side drives pushes and pop acceptance; the slave side is the FIFO.
interface adder_result_fifo_if #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic [7:0]       carry_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, full, empty, carry_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, full, empty, carry_cnt
  );
endinterface

// File: rtl/adder_result_fifo.sv
// Small register-array FIFO buffering 4-bit adder results {cout, sum}.
// Ready/valid are derived from occupancy only, so no combinational path
// exists from out_ready to in_ready. Also counts carry-out results seen.
// DEPTH must be a power of two and at least 2 so pointers wrap naturally.
module adder_result_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  adder_result_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} status_t;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_carry_cnt;

  status_t w_status;
  logic    w_push;
  logic    w_pop;

  // Occupancy class decoded from the registered count (glitch-free source).
  always_comb begin
    w_status = ST_PARTIAL;
    if (r_count == '0) begin
      w_status = ST_EMPTY;
    end else if (r_count == CNT_W'(DEPTH)) begin
      w_status = ST_FULL;
    end
  end

  assign bus.full      = (w_status == ST_FULL);
  assign bus.empty     = (w_status == ST_EMPTY);
  assign bus.in_ready  = (w_status != ST_FULL);
  assign bus.out_valid = (w_status != ST_EMPTY);
  assign bus.out_data  = r_mem[r_rd_ptr];
  assign bus.count     = r_count;
  assign bus.carry_cnt = r_carry_cnt;

  assign w_push = bus.in_valid && (w_status != ST_FULL);
  assign w_pop  = bus.out_ready && (w_status != ST_EMPTY);

  // Storage is not reset; each entry captures data when the write pointer selects it.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
          r_mem[gi] <= bus.in_data;
        end
      end
    end
  endgenerate

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturating count of accepted entries carrying a carry-out; pops ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_carry_cnt <= '0;
    end else if (w_push && bus.in_data[WIDTH-1] && (r_carry_cnt != 8'hFF)) begin
      r_carry_cnt <= r_carry_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_adder_result_fifo.sv
// Directed and model-checked bench for adder_result_fifo (WIDTH=5, DEPTH=4).
module tb_adder_result_fifo;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  adder_result_fifo_if #(.WIDTH(5), .DEPTH(4)) bus ();

  adder_result_fifo #(.WIDTH(5), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    #2;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.carry_cnt !== 8'd0) begin errors++; $display("FAIL reset_carry got=%0d exp=0", bus.carry_cnt); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    $display("reset released at %0t", $time);
  endtask

  // Push four results right after reset release with the consumer stalled.
  task automatic test_fill();
    logic [4:0] vals [4];
    vals[0] = 5'h13; vals[1] = 5'h0F; vals[2] = 5'h1E; vals[3] = 5'h07;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = vals[i];
      tick();
      $display("push data=%h", vals[i]);
      checks++; if (bus.count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, bus.count, i + 1); end
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", bus.full); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.carry_cnt !== 8'd2) begin errors++; $display("FAIL fill_carry got=%0d exp=2", bus.carry_cnt); end
    checks++; if (bus.out_data !== 5'h13) begin errors++; $display("FAIL fill_out_data got=%h exp=13", bus.out_data); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL fill_out_valid got=%b exp=1", bus.out_valid); end
  endtask

  // Offer data while full, then drain; the held-off entry follows once space opens.
  task automatic test_full_hold();
    logic [4:0] exp [5];
    exp[0] = 5'h13; exp[1] = 5'h0F; exp[2] = 5'h1E; exp[3] = 5'h07; exp[4] = 5'h1F;
    bus.in_valid = 1'b1;
    bus.in_data = 5'h1F;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("hold cycle %0d count=%0d", i, bus.count);
      checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL hold_count[%0d] got=%0d exp=4", i, bus.count); end
      checks++; if (bus.carry_cnt !== 8'd2) begin errors++; $display("FAIL hold_carry[%0d] got=%0d exp=2", i, bus.carry_cnt); end
      checks++; if (bus.out_data !== 5'h13) begin errors++; $display("FAIL hold_head[%0d] got=%h exp=13", i, bus.out_data); end
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp[k]) begin
        errors++; $display("FAIL drain_data[%0d] got=%h valid=%b exp=%h", k, bus.out_data, bus.out_valid, exp[k]);
      end
      tick();
      $display("pop data=%h", exp[k]);
      if (k == 0) begin
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL full_pop_count got=%0d exp=3", bus.count); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_in_ready got=%b exp=1", bus.in_ready); end
      end
    end
    bus.out_ready = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL drain_count got=%0d exp=0", bus.count); end
    checks++; if (bus.carry_cnt !== 8'd3) begin errors++; $display("FAIL drain_carry got=%0d exp=3", bus.carry_cnt); end
  endtask

  // Pop request on an empty FIFO does nothing.
  task automatic test_empty_pop();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    $display("pop request while empty");
    bus.out_ready = 1'b0;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL empty_pop_count got=%0d exp=0", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL empty_pop_valid got=%b exp=0", bus.out_valid); end
  endtask

  // Steady streaming at occupancy 1; output trails input by one entry.
  task automatic test_back_to_back();
    bus.in_valid = 1'b1;
    bus.in_data = 5'd0;
    bus.out_ready = 1'b1;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL b2b_start_empty got=%b exp=1", bus.empty); end
    tick();
    $display("push data=00");
    checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL b2b_first_count got=%0d exp=1", bus.count); end
    for (int i = 1; i <= 10; i++) begin
      bus.in_data = 5'(i);
      checks++; if (bus.out_data !== 5'(i - 1)) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, bus.out_data, 5'(i - 1)); end
      tick();
      $display("push data=%h pop data=%h", 5'(i), 5'(i - 1));
      checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL b2b_count[%0d] got=%0d exp=1", i, bus.count); end
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.out_data !== 5'd10) begin errors++; $display("FAIL b2b_last got=%h exp=0a", bus.out_data); end
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL b2b_end_count got=%0d exp=0", bus.count); end
    checks++; if (bus.carry_cnt !== 8'd3) begin errors++; $display("FAIL b2b_carry got=%0d exp=3", bus.carry_cnt); end
  endtask

  // 300 carry-set pushes while draining drive carry_cnt into saturation.
  task automatic test_carry_sat();
    int exp_c;
    exp_c = 3;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 5'h10 | 5'(i & 15);
      tick();
      if (exp_c < 255) exp_c++;
      if (i % 50 == 0) $display("carry push %0d carry_cnt=%0d", i, bus.carry_cnt);
      checks++; if (bus.carry_cnt !== 8'(exp_c)) begin errors++; $display("FAIL carry[%0d] got=%0d exp=%0d", i, bus.carry_cnt, exp_c); end
    end
    bus.in_valid = 1'b0;
    tick();
    tick();
    checks++; if (bus.carry_cnt !== 8'd255) begin errors++; $display("FAIL carry_hold got=%0d exp=255", bus.carry_cnt); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL carry_drained got=%b exp=1", bus.empty); end
    bus.out_ready = 1'b0;
  endtask

  // Reset asserted between edges clears state without a clock edge.
  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 5'h11 + 5'(i);
      tick();
      $display("push data=%h", bus.in_data);
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL ar_pre_count got=%0d exp=3", bus.count); end
    #2;
    rst = 1'b1;
    #1;
    $display("async reset asserted at %0t", $time);
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL ar_count got=%0d exp=0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL ar_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.carry_cnt !== 8'd0) begin errors++; $display("FAIL ar_carry got=%0d exp=0", bus.carry_cnt); end
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
      errors++; $display("FAIL ar_after valid=%b count=%0d exp valid=0 count=0", bus.out_valid, bus.count);
    end
  endtask

  // Random valid/ready traffic compared against a queue reference.
  task automatic test_random();
    logic [4:0] q [$];
    logic [4:0] d;
    int         m_carry;
    bit         m_push;
    bit         m_pop;
    m_carry = 0;
    for (int c = 0; c < 10000; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      d = 5'($urandom);
      bus.in_data = d;
      bus.out_ready = 1'($urandom_range(0, 1));
      checks++; if (bus.count !== 3'(q.size())) begin errors++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", c, bus.count, q.size()); end
      checks++; if (bus.in_ready !== (q.size() != 4)) begin errors++; $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", c, bus.in_ready, q.size() != 4); end
      if (q.size() > 0) begin
        checks++; if (bus.out_data !== q[0] || bus.out_valid !== 1'b1) begin
          errors++; $display("FAIL rnd_data[%0d] got=%h valid=%b exp=%h", c, bus.out_data, bus.out_valid, q[0]);
        end
      end
      m_push = bus.in_valid && (q.size() < 4);
      m_pop  = bus.out_ready && (q.size() > 0);
      tick();
      if (m_pop) begin
        $display("rnd %0d pop data=%h", c, q[0]);
        void'(q.pop_front());
      end
      if (m_push) begin
        $display("rnd %0d push data=%h", c, d);
        q.push_back(d);
        if (d[4] && m_carry < 255) m_carry++;
      end
      checks++; if (bus.carry_cnt !== 8'(m_carry)) begin errors++; $display("FAIL rnd_carry[%0d] got=%0d exp=%0d", c, bus.carry_cnt, m_carry); end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_fill();
    test_full_hold();
    test_empty_pop();
    test_back_to_back();
    test_carry_sat();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adder_result_fifo.md
ADDER_RESULT_FIFO -- requirements
Module: adder_result_fifo

Interface
REQ-001 Parameter WIDTH, default 5: entry width, matching the 4-bit adder result as {cout, sum[3:0]}; bit WIDTH-1 is the carry-out.
REQ-002 Parameter DEPTH, default 4: number of entries; power of two, at least 2.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1: upstream adder result is present on in_data.
REQ-006 Port in_data, input, WIDTH: adder result {cout, sum}.
REQ-007 Port in_ready, output, 1: FIFO can accept an entry this cycle.
REQ-008 Port out_valid, output, 1: out_data holds the oldest entry.
REQ-009 Port out_data, output, WIDTH: oldest entry, driven from storage.
REQ-010 Port out_ready, input, 1: downstream accepts out_data this cycle.
REQ-011 Port count, output, clog2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-012 Port full, output, 1: count == DEPTH.
REQ-013 Port empty, output, 1: count == 0.
REQ-014 Port carry_cnt, output, 8: saturating count of accepted entries with bit WIDTH-1 = 1.

Function
REQ-015 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready; both are evaluated at the same rising edge.
REQ-016 in_ready SHALL be !full, with no dependency on out_ready, so there is no combinational ready path through the block.
REQ-017 out_valid SHALL be !empty; out_data SHALL equal the entry at the read pointer; out_data is don't-care when empty.
REQ-018 Storage is a DEPTH-entry register array; write pointer and read pointer each advance by 1 modulo DEPTH on push and pop respectively, wrapping from DEPTH-1 to 0.
REQ-019 Ordering is strict FIFO: entries leave in acceptance order, bit-exact.
REQ-020 Push latency: a value pushed at edge N is visible on out_data with out_valid=1 after edge N if the FIFO was empty; there is no fall-through in the same cycle.
REQ-021 Occupancy update per edge:
  - push only: count+1
  - pop only: count-1
  - push and pop together: count unchanged, both pointers advance
  - neither: unchanged
REQ-022 Simultaneous push and pop when full: the push cannot occur because in_ready=0; only the pop occurs, count goes to DEPTH-1, and in_ready returns to 1 the next cycle.
REQ-023 Simultaneous push and pop when empty: the pop cannot occur because out_valid=0; only the push occurs, count goes to 1.
REQ-024 in_valid while full is not an error: data is held off by in_ready=0, nothing is lost, and the pointers and count are unchanged.
REQ-025 out_ready while empty has no effect.
REQ-026 carry_cnt increments by 1 on each push whose in_data[WIDTH-1]=1, and saturates at 255 (holds at 255).
REQ-027 Pops never affect carry_cnt.
REQ-028 A state machine is not required; the status state is {EMPTY, PARTIAL, FULL} derived from count, and full/empty are registered or derived from count with no glitch-visible combinational loops.

Reset
REQ-029 While rst=1, asynchronously:
  - pointers = 0, count = 0, carry_cnt = 0
  - empty=1, full=0, in_ready=1, out_valid=0
REQ-030 Storage array contents need not be reset.
REQ-031 Reset asserted mid-operation discards all stored entries; no pop is reported after reset until a new push.
REQ-032 Deassertion of rst takes effect at the next rising edge of clk; a push presented in the first cycle after deassertion SHALL be accepted.

Verification
REQ-033 Reset then push 5'h13, 5'h0F, 5'h1E, 5'h07 with out_ready=0 -> count=4, full=1, in_ready=0, carry_cnt=2, out_data=5'h13.
REQ-034 From full, hold in_valid=1 with in_data=5'h1F for 3 cycles and out_ready=0 -> no change in count or carry_cnt; then drain with out_ready=1 -> outputs 13,0F,1E,07 in order, then 1F pushed after in_ready rises.
REQ-035 Continuous in_valid=1 and out_ready=1 from count=1 for 10 cycles with incrementing data -> count stays 1, pointers wrap at least twice, output sequence equals input sequence delayed by one entry.
REQ-036 Push 300 entries all with bit4=1 while draining -> carry_cnt=255 and holds.
REQ-037 Assert rst asynchronously between edges with count=3 -> count=0, empty=1, out_valid=0, carry_cnt=0 immediately, without waiting for a clock edge.
REQ-038 Random valid/ready stimulus for 10k cycles against a reference queue model -> no loss, no duplication, no reordering, and count always matches the model.
